// File: rtl/bus_line_fetcher.sv
// Line-bus memory-side slave: serves 128-bit line reads/writes from a 32-bit word memory port,
// four beats per line. Keeps the last served line so a repeated address costs no memory traffic.
module bus_line_fetcher #(
    parameter int unsigned BUS_ADDRESS_WIDTH    = 20,
    parameter int unsigned BUS_DATA_WIDTH_SHIFT = 4
) (
    input  logic                                            clk_i,
    input  logic                                            rst_i,
    input  logic [BUS_ADDRESS_WIDTH-BUS_DATA_WIDTH_SHIFT-1:0] bus_addr_i,
    input  logic [127:0]                                    bus_data_i,
    input  logic                                            bus_we_i,
    output logic [127:0]                                    bus_data_o,
    output logic                                            bus_valid_o,
    output logic                                            mem_req_o,
    output logic                                            mem_we_o,
    output logic [BUS_ADDRESS_WIDTH-3:0]                    mem_addr_o,
    output logic [31:0]                                     mem_wdata_o,
    input  logic [31:0]                                     mem_rdata_i,
    input  logic                                            mem_ack_i
);

    localparam int unsigned LINE_AW = BUS_ADDRESS_WIDTH - BUS_DATA_WIDTH_SHIFT;
    localparam int unsigned BEATS   = 2 ** (BUS_DATA_WIDTH_SHIFT - 2);

    typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

    state_e               r_state;
    logic [LINE_AW-1:0]   r_line_addr;
    logic                 r_line_vld;
    logic                 r_wr_done;
    logic [1:0]           r_beat;
    logic [127:0]         r_wline;
    logic [127:0]         r_bus_data;
    logic                 r_mem_req;
    logic                 r_mem_we;
    logic [LINE_AW+1:0]   r_mem_addr;
    logic [31:0]          r_mem_wdata;

    logic                 w_addr_match;
    logic                 w_hit;
    logic                 w_last;
    logic [1:0]           w_beat_nxt;

    // Hit/last-beat decode shared by the FSM and the valid output
    always_comb begin
        w_addr_match = (r_line_addr == bus_addr_i);
        w_hit        = r_line_vld & w_addr_match;
        w_last       = (r_beat == 2'(BEATS - 1));
        w_beat_nxt   = r_beat + 2'd1;
    end

    // Valid is combinational on the live address so it drops the cycle the address moves;
    // a held write request is only acknowledged once that write actually finished.
    always_comb begin
        bus_valid_o = (r_state == StIdle) & w_hit & (bus_we_i ? r_wr_done : 1'b1);
    end

    assign bus_data_o  = r_bus_data;
    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;

    // Line sequencer: all state and the registered memory-side outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= StIdle;
            r_line_addr <= '0;
            r_line_vld  <= 1'b0;
            r_wr_done   <= 1'b0;
            r_beat      <= 2'd0;
            r_wline     <= '0;
            r_bus_data  <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    // A repeat write to the same line needs we to drop first
                    if (!bus_we_i) begin
                        r_wr_done <= 1'b0;
                    end
                    if (bus_we_i && !(w_hit && r_wr_done)) begin
                        r_state     <= StWr;
                        r_line_addr <= bus_addr_i;
                        r_line_vld  <= 1'b0;
                        r_wr_done   <= 1'b0;
                        r_beat      <= 2'd0;
                        r_wline     <= bus_data_i;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= {bus_addr_i, 2'd0};
                        r_mem_wdata <= bus_data_i[31:0];
                    end else if (!w_hit) begin
                        r_state     <= StRd;
                        r_line_addr <= bus_addr_i;
                        r_line_vld  <= 1'b0;
                        r_wr_done   <= 1'b0;
                        r_beat      <= 2'd0;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= {bus_addr_i, 2'd0};
                    end
                end

                StRd: begin
                    if (mem_ack_i) begin
                        if (!w_last && !w_addr_match) begin
                            // Requester moved on: drop this word and restart on the new line.
                            // The request stays up, only the address changes after the ack.
                            r_line_addr <= bus_addr_i;
                            r_beat      <= 2'd0;
                            r_mem_addr  <= {bus_addr_i, 2'd0};
                        end else begin
                            r_bus_data[{r_beat, 5'd0} +: 32] <= mem_rdata_i;
                            if (w_last) begin
                                r_state    <= StIdle;
                                r_line_vld <= 1'b1;
                                r_mem_req  <= 1'b0;
                            end else begin
                                r_beat     <= w_beat_nxt;
                                r_mem_addr <= {r_line_addr, w_beat_nxt};
                            end
                        end
                    end
                end

                StWr: begin
                    // Writes are atomic: bus inputs are not looked at until the last beat
                    if (mem_ack_i) begin
                        if (w_last) begin
                            r_state    <= StIdle;
                            r_bus_data <= r_wline;
                            r_line_vld <= 1'b1;
                            r_wr_done  <= 1'b1;
                            r_mem_req  <= 1'b0;
                            r_mem_we   <= 1'b0;
                        end else begin
                            r_beat      <= w_beat_nxt;
                            r_mem_addr  <= {r_line_addr, w_beat_nxt};
                            r_mem_wdata <= r_wline[{w_beat_nxt, 5'd0} +: 32];
                        end
                    end
                end

                default: begin
                    r_state   <= StIdle;
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_line_fetcher.sv
// Directed bench for bus_line_fetcher with a wait-state memory model and a beat scoreboard.
module tb_bus_line_fetcher;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [15:0]  bus_addr_i;
    logic [127:0] bus_data_i;
    logic         bus_we_i;
    logic [127:0] bus_data_o;
    logic         bus_valid_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [17:0]  mem_addr_o;
    logic [31:0]  mem_wdata_o;
    logic [31:0]  mem_rdata_i;
    logic         mem_ack_i;

    typedef struct packed {
        logic [17:0] addr;
        logic        we;
        logic [31:0] wdata;
    } beat_t;

    beat_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    wait_cfg = 0;
    int    wcnt = 0;

    localparam logic [127:0] WLINE  = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    localparam logic [127:0] WLINE2 = 128'h8888_8888_7777_7777_6666_6666_5555_5555;

    bus_line_fetcher #(
        .BUS_ADDRESS_WIDTH   (20),
        .BUS_DATA_WIDTH_SHIFT(4)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .bus_addr_i (bus_addr_i),
        .bus_data_i (bus_data_i),
        .bus_we_i   (bus_we_i),
        .bus_data_o (bus_data_o),
        .bus_valid_o(bus_valid_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i),
        .mem_ack_i  (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    // Memory model: word n reads as A000_0000+n; acks after wait_cfg wait cycles
    assign mem_ack_i   = mem_req_o && (wcnt >= wait_cfg);
    assign mem_rdata_i = 32'hA000_0000 + {14'd0, mem_addr_o};

    always @(posedge clk_i) begin
        if (mem_req_o && !mem_ack_i) wcnt <= wcnt + 1;
        else                         wcnt <= 0;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted beat must match the next expected one
    always @(negedge clk_i) begin
        if (rst_i && mem_req_o && mem_ack_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {110'd0, mem_addr_o}, 128'd0);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check("beat_addr", {110'd0, mem_addr_o}, {110'd0, e.addr});
                check("beat_we", {127'd0, mem_we_o}, {127'd0, e.we});
                if (e.we) check("beat_wdata", {96'd0, mem_wdata_o}, {96'd0, e.wdata});
            end
        end
    end

    function automatic logic [127:0] rd_line(input logic [15:0] la);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[32*k +: 32] = 32'hA000_0000 + {14'd0, la, 2'(k)};
        return l;
    endfunction

    task automatic push_rd(input logic [15:0] la, input int first, input int last);
        for (int k = first; k <= last; k++) exp_q.push_back('{{la, 2'(k)}, 1'b0, 32'd0});
    endtask

    task automatic push_wr(input logic [15:0] la, input logic [127:0] line);
        for (int k = 0; k < 4; k++) exp_q.push_back('{{la, 2'(k)}, 1'b1, line[32*k +: 32]});
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int bad_req;
        int bad_vld;
        rst_i      = 1'b0;
        bus_addr_i = 16'h0010;
        bus_we_i   = 1'b0;
        bus_data_i = '0;
        tick();
        tick();
        check("rst_valid", {127'd0, bus_valid_o}, 128'd0);
        check("rst_req", {127'd0, mem_req_o}, 128'd0);
        check("rst_we", {127'd0, mem_we_o}, 128'd0);
        check("rst_addr", {110'd0, mem_addr_o}, 128'd0);
        check("rst_wdata", {96'd0, mem_wdata_o}, 128'd0);
        check("rst_data", bus_data_o, 128'd0);

        // Zero-wait read miss of line 0x0010
        push_rd(16'h0010, 0, 3);
        rst_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rd_req", {127'd0, mem_req_o}, 128'd1);
            check("rd_addr", {110'd0, mem_addr_o}, 128'h40 + 128'(k));
        end
        tick();
        check("rd_valid", {127'd0, bus_valid_o}, 128'd1);
        check("rd_data", bus_data_o, 128'hA000_0043_A000_0042_A000_0041_A000_0040);

        // Hold: no traffic, valid stays
        bad_req = 0;
        bad_vld = 0;
        repeat (100) begin
            tick();
            if (mem_req_o) bad_req++;
            if (!bus_valid_o) bad_vld++;
        end
        check("hold_req_cycles", 128'(bad_req), 128'd0);
        check("hold_invalid_cycles", 128'(bad_vld), 128'd0);

        // Async reset in the beat-2 request cycle
        bus_addr_i = 16'h0030;
        push_rd(16'h0030, 0, 1);
        tick();
        tick();
        tick();
        check("pre_rst_addr", {110'd0, mem_addr_o}, 128'hC2);
        rst_i = 1'b0;
        #1;
        check("midrst_req", {127'd0, mem_req_o}, 128'd0);
        check("midrst_valid", {127'd0, bus_valid_o}, 128'd0);
        check("midrst_addr", {110'd0, mem_addr_o}, 128'd0);
        tick();
        tick();
        push_rd(16'h0030, 0, 3);
        rst_i = 1'b1;
        tick();
        check("refetch_beat0", {110'd0, mem_addr_o}, 128'hC0);
        tick();
        tick();
        tick();
        tick();
        check("refetch_valid", {127'd0, bus_valid_o}, 128'd1);
        check("refetch_data", bus_data_o, rd_line(16'h0030));

        // Address change on the beat-1 ack restarts the line
        bus_addr_i = 16'h0010;
        push_rd(16'h0010, 0, 1);
        push_rd(16'h0020, 0, 3);
        tick();
        tick();
        check("abort_beat1_addr", {110'd0, mem_addr_o}, 128'h41);
        bus_addr_i = 16'h0020;
        tick();
        check("abort_restart_addr", {110'd0, mem_addr_o}, 128'h80);
        tick();
        tick();
        tick();
        tick();
        check("abort_valid", {127'd0, bus_valid_o}, 128'd1);
        check("abort_data", bus_data_o, rd_line(16'h0020));
        bus_addr_i = 16'h0010;
        #1;
        check("other_addr_valid", {127'd0, bus_valid_o}, 128'd0);
        bus_addr_i = 16'h0020;
        #1;
        check("back_addr_valid", {127'd0, bus_valid_o}, 128'd1);
        tick();
        check("abort_idle_req", {127'd0, mem_req_o}, 128'd0);

        // Two wait states per beat: address held stable, valid at cycle 13
        wait_cfg   = 2;
        bus_addr_i = 16'h0010;
        push_rd(16'h0010, 0, 3);
        bad_req = 0;
        bad_vld = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (!mem_req_o || mem_addr_o !== 18'(32'h40 + i / 3)) bad_req++;
            if (bus_valid_o) bad_vld++;
        end
        check("ws_addr_bad_cycles", 128'(bad_req), 128'd0);
        check("ws_early_valid_cycles", 128'(bad_vld), 128'd0);
        tick();
        check("ws_valid", {127'd0, bus_valid_o}, 128'd1);
        check("ws_data", bus_data_o, 128'hA000_0043_A000_0042_A000_0041_A000_0040);

        // Write line, low word first; bus inputs ignored while writing
        wait_cfg   = 0;
        bus_we_i   = 1'b1;
        bus_addr_i = 16'h0005;
        bus_data_i = WLINE;
        push_wr(16'h0005, WLINE);
        tick();
        check("wr_we", {127'd0, mem_we_o}, 128'd1);
        check("wr_addr0", {110'd0, mem_addr_o}, 128'h14);
        bus_data_i = ~WLINE;
        tick();
        tick();
        tick();
        check("wr_addr3", {110'd0, mem_addr_o}, 128'h17);
        check("wr_wdata3", {96'd0, mem_wdata_o}, 128'h4444_4444);
        tick();
        check("wr_valid", {127'd0, bus_valid_o}, 128'd1);
        check("wr_data", bus_data_o, WLINE);
        bus_we_i = 1'b0;
        #1;
        check("wr_read_valid", {127'd0, bus_valid_o}, 128'd1);
        bad_req = 0;
        repeat (10) begin
            tick();
            if (mem_req_o || !bus_valid_o) bad_req++;
        end
        check("wr_read_no_traffic", 128'(bad_req), 128'd0);
        check("wr_read_data", bus_data_o, WLINE);

        // Re-raising we on the same line is a new write
        bus_we_i   = 1'b1;
        bus_data_i = WLINE2;
        #1;
        check("rewr_valid_drop", {127'd0, bus_valid_o}, 128'd0);
        push_wr(16'h0005, WLINE2);
        repeat (5) tick();
        check("rewr_valid", {127'd0, bus_valid_o}, 128'd1);
        check("rewr_data", bus_data_o, WLINE2);
        bus_we_i = 1'b0;
        tick();
        check("sb_drained", 128'(exp_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
